mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the data port (port 1) of the team's async-read / sync-write byte-enabled dual-port RAM, ASYNC_RAM_DP_WBE.
- Requester 0 is the CPU load/store unit.
- Requester 1 is the debug/program loader that replaces $readmemh preload in system builds.
- Fixed priority to requester 0, with a starvation guard and a bus-lock for multi-beat sequences (read-modify-write, burst load).
- Read data is returned registered, one cycle after grant.

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester/RAM-side bundle of the two-port memory arbiter: both requester
// ports, the RAM data-port signals, and the arbiter's debug view of its state.
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
);
    logic                  m0_req;
    logic                  m0_lock;
    logic [AWIDTH-1:0]     m0_addr;
    logic                  m0_we;
    logic [DWIDTH/8-1:0]   m0_wbe;
    logic [DWIDTH-1:0]     m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DWIDTH-1:0]     m0_rdata;

    logic                  m1_req;
    logic                  m1_lock;
    logic [AWIDTH-1:0]     m1_addr;
    logic                  m1_we;
    logic [DWIDTH/8-1:0]   m1_wbe;
    logic [DWIDTH-1:0]     m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DWIDTH-1:0]     m1_rdata;

    logic [AWIDTH-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DWIDTH/8-1:0]   mem_wbe;
    logic [DWIDTH-1:0]     mem_d;
    logic [DWIDTH-1:0]     mem_q;

    logic [1:0]            dbg_owner;
    logic [7:0]            dbg_starve_cnt;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_we, m0_wbe, m0_wdata,
        input  m1_req, m1_lock, m1_addr, m1_we, m1_wbe, m1_wdata,
        input  mem_q,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wen, mem_wbe, mem_d,
        output dbg_owner, dbg_starve_cnt
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_we, m0_wbe, m0_wdata,
        output m1_req, m1_lock, m1_addr, m1_we, m1_wbe, m1_wdata,
        output mem_q,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wen, mem_wbe, mem_d,
        input  dbg_owner, dbg_starve_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the data port of ASYNC_RAM_DP_WBE: fixed priority
// to requester 0, starvation guard for requester 1, and per-requester bus lock.
module mem_port_arbiter #(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 32,
    parameter int STARVE_MAX = 8
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    // Handshake: a beat of requester k transfers in any cycle with mk_req and
    // mk_gnt both high (mk_gnt is combinational from mk_req); a granted read
    // returns mk_rdata with mk_rvalid high for exactly one cycle, one cycle later.
    typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} owner_t;

    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    owner_t              owner, owner_nxt;
    logic [7:0]          starve_cnt, starve_nxt;
    logic                gnt0, gnt1;
    logic [AWIDTH-1:0]   mux_addr;
    logic                mux_wen;
    logic [DWIDTH/8-1:0] mux_wbe;
    logic [DWIDTH-1:0]   mux_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= IDLE;
            starve_cnt <= 8'd0;
        end else begin
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        if (gnt0 && bus.m0_lock)
            owner_nxt = LOCK0;
        else if (gnt1 && bus.m1_lock)
            owner_nxt = LOCK1;
        else if (owner == LOCK0 && (!bus.m0_req || gnt0))
            owner_nxt = IDLE;
        else if (owner == LOCK1 && (!bus.m1_req || gnt1))
            owner_nxt = IDLE;

        // Counter keeps running under LOCK0 so requester 1 wins as soon as the lock ends.
        if (gnt1 || !bus.m1_req)
            starve_nxt = 8'd0;
        else if (starve_cnt != SMAX)
            starve_nxt = starve_cnt + 8'd1;
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            unique case (owner)
                LOCK0: gnt0 = bus.m0_req;
                LOCK1: gnt1 = bus.m1_req;
                default: begin
                    if (bus.m0_req && bus.m1_req) begin
                        if (starve_cnt == SMAX) gnt1 = 1'b1;
                        else                    gnt0 = 1'b1;
                    end else begin
                        gnt0 = bus.m0_req;
                        gnt1 = bus.m1_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mux_addr = bus.m0_addr;
        mux_wen  = 1'b0;
        mux_wbe  = '0;
        mux_d    = '0;
        if (gnt0) begin
            mux_wen = bus.m0_we;
            mux_wbe = bus.m0_wbe;
            mux_d   = bus.m0_wdata;
        end else if (gnt1) begin
            mux_addr = bus.m1_addr;
            mux_wen  = bus.m1_we;
            mux_wbe  = bus.m1_wbe;
            mux_d    = bus.m1_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.m0_rvalid <= 1'b0;
            bus.m0_rdata  <= '0;
            bus.m1_rvalid <= 1'b0;
            bus.m1_rdata  <= '0;
        end else begin
            bus.m0_rvalid <= gnt0 && !bus.m0_we;
            bus.m1_rvalid <= gnt1 && !bus.m1_we;
            if (gnt0 && !bus.m0_we) bus.m0_rdata <= bus.mem_q;
            if (gnt1 && !bus.m1_we) bus.m1_rdata <= bus.mem_q;
        end
    end

    assign bus.m0_gnt         = gnt0;
    assign bus.m1_gnt         = gnt1;
    assign bus.mem_addr       = mux_addr;
    assign bus.mem_wen        = mux_wen;
    assign bus.mem_wbe        = mux_wbe;
    assign bus.mem_d          = mux_d;
    assign bus.dbg_owner      = owner;
    assign bus.dbg_starve_cnt = starve_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural async-read/sync-write
// RAM and a reference memory feeding per-requester read-data queues.
module tb_mem_port_arbiter;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int SMAX = 8;
    localparam logic [1:0] O_IDLE = 2'd0, O_LOCK0 = 2'd1, O_LOCK1 = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_init = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] init_word(int i);
        return (i < 16) ? 32'(i) * 32'h1111_1111 : '0;
    endfunction

    assign bus.mem_q = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
        end else if (bus.mem_wen) begin
            for (int b = 0; b < DW / 8; b++)
                if (bus.mem_wbe[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_d[8*b +: 8];
        end
    end

    task automatic chk1(string tag, logic obs, logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(logic req, logic lock, logic [AW-1:0] addr, logic we,
                          logic [3:0] wbe, logic [DW-1:0] wdata);
        bus.m0_req = req; bus.m0_lock = lock; bus.m0_addr = addr;
        bus.m0_we = we; bus.m0_wbe = wbe; bus.m0_wdata = wdata;
    endtask

    task automatic drive1(logic req, logic lock, logic [AW-1:0] addr, logic we,
                          logic [3:0] wbe, logic [DW-1:0] wdata);
        bus.m1_req = req; bus.m1_lock = lock; bus.m1_addr = addr;
        bus.m1_we = we; bus.m1_wbe = wbe; bus.m1_wdata = wdata;
    endtask

    task automatic idle_all();
        drive0(1'b0, 1'b0, '0, 1'b0, 4'h0, '0);
        drive1(1'b0, 1'b0, '0, 1'b0, 4'h0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies the beat the bench currently drives for requester k to the reference memory.
    task automatic model_beat(int k);
        logic [AW-1:0] a;
        logic          we;
        logic [3:0]    wbe;
        logic [DW-1:0] wd;
        a   = (k == 0) ? bus.m0_addr  : bus.m1_addr;
        we  = (k == 0) ? bus.m0_we    : bus.m1_we;
        wbe = (k == 0) ? bus.m0_wbe   : bus.m1_wbe;
        wd  = (k == 0) ? bus.m0_wdata : bus.m1_wdata;
        if (we) begin
            for (int b = 0; b < DW / 8; b++)
                if (wbe[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else if (k == 0) begin
            exp_q0.push_back(ref_mem[a]);
        end else begin
            exp_q1.push_back(ref_mem[a]);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.m0_rvalid) begin
                if (exp_q0.size() == 0) chk1("m0 rvalid unexpected", bus.m0_rvalid, 1'b0);
                else                    chk32("m0 rdata sb", bus.m0_rdata, exp_q0.pop_front());
            end
            if (bus.m1_rvalid) begin
                if (exp_q1.size() == 0) chk1("m1 rvalid unexpected", bus.m1_rvalid, 1'b0);
                else                    chk32("m1 rdata sb", bus.m1_rdata, exp_q1.pop_front());
            end
        end
    end

    initial begin
        logic e1;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
        idle_all();
        #2;
        chk1("rst m0_rvalid", bus.m0_rvalid, 1'b0);
        chk1("rst m1_rvalid", bus.m1_rvalid, 1'b0);
        chk32("rst m0_rdata", bus.m0_rdata, 32'h0);
        chk32("rst m1_rdata", bus.m1_rdata, 32'h0);
        chk32("rst owner", 32'(bus.dbg_owner), 32'(O_IDLE));
        chk32("rst starve", 32'(bus.dbg_starve_cnt), 32'd0);
        drive0(1'b1, 1'b0, 12'd0, 1'b0, 4'h0, '0);
        drive1(1'b1, 1'b0, 12'd0, 1'b0, 4'h0, '0);
        #1;
        chk1("rst m0_gnt forced", bus.m0_gnt, 1'b0);
        chk1("rst m1_gnt forced", bus.m1_gnt, 1'b0);
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        ram_init = 1'b0;
        reset = 1'b0;

        // m1 alone reads addr 2
        drive1(1'b1, 1'b0, 12'd2, 1'b0, 4'h0, '0);
        #1;
        chk1("t1 m1_gnt", bus.m1_gnt, 1'b1);
        chk1("t1 m0_gnt", bus.m0_gnt, 1'b0);
        chk32("t1 mem_addr", 32'(bus.mem_addr), 32'd2);
        model_beat(1);
        tick();
        chk1("t1 m1_rvalid", bus.m1_rvalid, 1'b1);
        chk32("t1 m1_rdata", bus.m1_rdata, 32'h2222_2222);
        idle_all();
        tick();
        chk1("t1 m1_rvalid drops", bus.m1_rvalid, 1'b0);
        chk32("t1 m1_rdata holds", bus.m1_rdata, 32'h2222_2222);

        // partial-byte write then read-after-write; wbe=0 write changes nothing
        drive0(1'b1, 1'b0, 12'd1, 1'b1, 4'b1000, 32'hAAAA_AAAA);
        #1;
        chk1("t3 m0_gnt", bus.m0_gnt, 1'b1);
        chk1("t3 mem_wen", bus.mem_wen, 1'b1);
        chk32("t3 mem_wbe", 32'(bus.mem_wbe), 32'h8);
        chk32("t3 mem_d", bus.mem_d, 32'hAAAA_AAAA);
        model_beat(0);
        tick();
        drive0(1'b1, 1'b0, 12'd1, 1'b1, 4'b0000, 32'hFFFF_FFFF);
        model_beat(0);
        tick();
        drive0(1'b1, 1'b0, 12'd1, 1'b0, 4'h0, '0);
        model_beat(0);
        tick();
        chk1("t3 m0_rvalid", bus.m0_rvalid, 1'b1);
        chk32("t3 m0_rdata", bus.m0_rdata, 32'hAA11_1111);
        idle_all();
        tick();

        // both reading continuously: m1 wins every 9th cycle
        drive0(1'b1, 1'b0, 12'd5, 1'b0, 4'h0, '0);
        drive1(1'b1, 1'b0, 12'd7, 1'b0, 4'h0, '0);
        for (int c = 0; c < 18; c++) begin
            #1;
            e1 = ((c % 9) == 8);
            chk1("t2 m0_gnt", bus.m0_gnt, !e1);
            chk1("t2 m1_gnt", bus.m1_gnt, e1);
            chk32("t2 starve", 32'(bus.dbg_starve_cnt), 32'(c % 9));
            model_beat(e1 ? 1 : 0);
            tick();
        end
        idle_all();
        tick();

        // LOCK0 holds off m1 even at saturation; m1 wins right after unlock
        drive0(1'b1, 1'b1, 12'd0, 1'b0, 4'h0, '0);
        drive1(1'b1, 1'b0, 12'd7, 1'b0, 4'h0, '0);
        for (int c = 0; c < 11; c++) begin
            #1;
            chk1("l0 m0_gnt", bus.m0_gnt, 1'b1);
            chk1("l0 m1_gnt", bus.m1_gnt, 1'b0);
            chk32("l0 starve", 32'(bus.dbg_starve_cnt), 32'((c < SMAX) ? c : SMAX));
            chk32("l0 owner", 32'(bus.dbg_owner), 32'((c == 0) ? O_IDLE : O_LOCK0));
            model_beat(0);
            tick();
        end
        drive0(1'b1, 1'b0, 12'd0, 1'b0, 4'h0, '0);
        #1;
        chk1("l0 last m0_gnt", bus.m0_gnt, 1'b1);
        model_beat(0);
        tick();
        #1;
        chk32("l0 owner released", 32'(bus.dbg_owner), 32'(O_IDLE));
        chk1("l0 m1_gnt after unlock", bus.m1_gnt, 1'b1);
        chk1("l0 m0_gnt after unlock", bus.m0_gnt, 1'b0);
        model_beat(1);
        tick();
        idle_all();
        tick();

        // m1 locked write burst to 4/5/6 while m0 keeps requesting
        drive0(1'b1, 1'b0, 12'd0, 1'b0, 4'h0, '0);
        drive1(1'b1, 1'b1, 12'd4, 1'b1, 4'hF, 32'h4444_0004);
        for (int c = 0; c < SMAX; c++) begin
            #1;
            chk1("t4 pre m0_gnt", bus.m0_gnt, 1'b1);
            model_beat(0);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive1(1'b1, (c < 2), 12'(4 + c), 1'b1, 4'hF, 32'h4444_0004 + 32'(c));
            #1;
            chk1("t4 m1_gnt", bus.m1_gnt, 1'b1);
            chk1("t4 m0_gnt", bus.m0_gnt, 1'b0);
            chk32("t4 mem_addr", 32'(bus.mem_addr), 32'(4 + c));
            chk32("t4 owner", 32'(bus.dbg_owner), 32'((c == 0) ? O_IDLE : O_LOCK1));
            model_beat(1);
            tick();
        end
        drive1(1'b0, 1'b0, '0, 1'b0, 4'h0, '0);
        #1;
        chk32("t4 owner idle", 32'(bus.dbg_owner), 32'(O_IDLE));
        chk1("t4 m0_gnt resumes", bus.m0_gnt, 1'b1);
        model_beat(0);
        tick();
        idle_all();
        tick();
        chk32("t4 ram4", ram[4], 32'h4444_0004);
        chk32("t4 ram5", ram[5], 32'h4444_0005);
        chk32("t4 ram6", ram[6], 32'h4444_0006);

        // no grant: address follows m0, everything else quiet
        drive0(1'b0, 1'b0, 12'h5A5, 1'b1, 4'hF, 32'hDEAD_BEEF);
        #1;
        chk32("ng mem_addr", 32'(bus.mem_addr), 32'h5A5);
        chk1("ng mem_wen", bus.mem_wen, 1'b0);
        chk32("ng mem_wbe", 32'(bus.mem_wbe), 32'h0);
        chk32("ng mem_d", bus.mem_d, 32'h0);
        tick();

        // simultaneous writes to addr 3: m0 first, m1 next cycle overwrites
        drive0(1'b1, 1'b0, 12'd3, 1'b1, 4'hF, 32'h3030_3030);
        drive1(1'b1, 1'b0, 12'd3, 1'b1, 4'hF, 32'h3131_3131);
        #1;
        chk1("t6 m0_gnt", bus.m0_gnt, 1'b1);
        chk1("t6 m1_gnt", bus.m1_gnt, 1'b0);
        chk32("t6 mem_d", bus.mem_d, 32'h3030_3030);
        model_beat(0);
        tick();
        chk32("t6 ram3 m0", ram[3], 32'h3030_3030);
        drive0(1'b0, 1'b0, '0, 1'b0, 4'h0, '0);
        #1;
        chk1("t6 m1_gnt next", bus.m1_gnt, 1'b1);
        model_beat(1);
        tick();
        chk32("t6 ram3 m1", ram[3], 32'h3131_3131);
        idle_all();
        tick();

        // reset mid-LOCK1 with read data in flight
        drive1(1'b1, 1'b1, 12'd2, 1'b0, 4'h0, '0);
        #1;
        model_beat(1);
        tick();
        chk32("t5 owner lock1", 32'(bus.dbg_owner), 32'(O_LOCK1));
        chk1("t5 m1_rvalid before", bus.m1_rvalid, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk1("t5 m1_rvalid reset", bus.m1_rvalid, 1'b0);
        chk32("t5 m1_rdata reset", bus.m1_rdata, 32'h0);
        chk32("t5 m0_rdata reset", bus.m0_rdata, 32'h0);
        chk32("t5 owner reset", 32'(bus.dbg_owner), 32'(O_IDLE));
        chk1("t5 m1_gnt in reset", bus.m1_gnt, 1'b0);
        exp_q1.delete();
        tick();
        reset = 1'b0;
        drive1(1'b0, 1'b0, '0, 1'b0, 4'h0, '0);
        drive0(1'b1, 1'b0, 12'd3, 1'b0, 4'h0, '0);
        #1;
        chk1("t5 m0_gnt after reset", bus.m0_gnt, 1'b1);
        model_beat(0);
        tick();
        chk32("t5 m0_rdata", bus.m0_rdata, 32'h3131_3131);
        idle_all();
        repeat (2) tick();

        chk32("end exp_q0 empty", 32'(exp_q0.size()), 32'd0);
        chk32("end exp_q1 empty", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
